// File: rtl/tick_sched_if.sv
// tick_sched_if: config/ack/event bundle for tick_sched; miss_cnt exists only with TICK_SCHED_MISS_CNT_EN
interface tick_sched_if #(
  parameter int N_CH  = 4,
  parameter int PER_W = 16,
  parameter int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
);
  logic              enable;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [1:0]        cfg_op;
  logic [PER_W-1:0]  cfg_period;
  logic [N_CH-1:0]   evt_ack;
  logic              base_tick;
  logic [N_CH-1:0]   evt_pend;
  logic [N_CH-1:0]   miss;
  logic [N_CH-1:0]   busy;
`ifdef TICK_SCHED_MISS_CNT_EN
  logic [8*N_CH-1:0] miss_cnt;
`endif
  modport master (
    output enable, cfg_we, cfg_ch, cfg_op, cfg_period, evt_ack,
    input  base_tick, evt_pend, miss, busy
`ifdef TICK_SCHED_MISS_CNT_EN
    , miss_cnt
`endif
  );
  modport slave (
    input  enable, cfg_we, cfg_ch, cfg_op, cfg_period, evt_ack,
    output base_tick, evt_pend, miss, busy
`ifdef TICK_SCHED_MISS_CNT_EN
    , miss_cnt
`endif
  );
endinterface

// File: rtl/tick_sched.sv
// tick_sched: shared prescaler plus N_CH periodic/one-shot countdown channels with pending/miss flags.
// Optional per-channel saturating miss counter under TICK_SCHED_MISS_CNT_EN.
module tick_sched #(
  parameter int SRC_FREQ  = 5000,
  parameter int BASE_FREQ = 1000,
  parameter int N_CH      = 4,
  parameter int PER_W     = 16
) (
  input logic         src_clk,
  input logic         rst,
  tick_sched_if.slave bus
);
  localparam int PRESC = SRC_FREQ / BASE_FREQ;
  localparam int PW    = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  typedef enum logic [1:0] {IDLE, RUN_P, RUN_1} state_t;
  logic [PW-1:0] pc_q;
  logic          tick_q, last, tick;
  assign last = pc_q == PW'(PRESC - 1);
  // A tick registered just before enable drops is not counted by the channels.
  assign tick = tick_q && bus.enable;
  assign bus.base_tick = tick_q;
  always_ff @(posedge src_clk) begin
    if (rst || !bus.enable) begin
      pc_q   <= '0;
      tick_q <= 1'b0;
    end else begin
      pc_q   <= last ? '0 : pc_q + PW'(1);
      tick_q <= last;
    end
  end
  genvar c;
  for (c = 0; c < N_CH; c++) begin : g_ch
    state_t           st_q, st_d;
    logic [PER_W-1:0] cnt_q, cnt_d, per_q, per_d;
    logic             pend_q, pend_d, miss_q, miss_d, fire, sel, ack;
    assign sel = bus.cfg_we && bus.cfg_ch == CH_W'(c);
    assign ack = bus.evt_ack[c];
    always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      fire  = 1'b0;
      per_d = (sel && bus.cfg_op == 2'b00) ? bus.cfg_period : per_q;
      if (sel && (bus.cfg_op[1] != bus.cfg_op[0]) && per_q != '0) begin
        st_d  = bus.cfg_op[0] ? RUN_P : RUN_1;
        cnt_d = per_q;
      end else if (sel && bus.cfg_op == 2'b11) begin
        st_d = IDLE;
      end else if (tick && st_q != IDLE) begin
        fire  = cnt_q <= PER_W'(1);
        cnt_d = fire ? per_q : cnt_q - PER_W'(1);
        st_d  = (fire && st_q == RUN_1) ? IDLE : st_q;
      end
      pend_d = ack ? fire : (pend_q || fire);
      miss_d = !ack && (miss_q || (fire && pend_q));
    end
    always_ff @(posedge src_clk) begin
      if (rst) begin
        st_q   <= IDLE;
        cnt_q  <= '0;
        per_q  <= '0;
        pend_q <= 1'b0;
        miss_q <= 1'b0;
      end else begin
        st_q   <= st_d;
        cnt_q  <= cnt_d;
        per_q  <= per_d;
        pend_q <= pend_d;
        miss_q <= miss_d;
      end
    end
    assign bus.evt_pend[c] = pend_q;
    assign bus.miss[c]     = miss_q;
    assign bus.busy[c]     = st_q != IDLE;
`ifdef TICK_SCHED_MISS_CNT_EN
    logic [7:0] mc_q;
    always_ff @(posedge src_clk) begin
      if (rst || ack)
        mc_q <= '0;
      else if (fire && pend_q && mc_q != 8'hff)
        mc_q <= mc_q + 8'd1;
    end
    assign bus.miss_cnt[8*c +: 8] = mc_q;
`endif
  end
endmodule

// File: tb/tb_tick_sched.sv
// tb_tick_sched: directed + random stimulus against a tick/countdown reference model of tick_sched.
module tb_tick_sched;
  localparam int PRESC = 4;
  localparam int NCH   = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad   = 0;
  tick_sched_if #(.N_CH(NCH), .PER_W(16)) bus ();
  tick_sched #(.SRC_FREQ(8), .BASE_FREQ(2), .N_CH(NCH), .PER_W(16)) dut (
    .src_clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  int  m_phase;
  bit  m_tick;
  int  mode [NCH];
  int  rem  [NCH];
  int  per  [NCH];
  bit  pend [NCH];
  bit  miss [NCH];
  int  mc   [NCH];
  logic [NCH-1:0] auto_ack = '0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [NCH-1:0] m_mask(input int sel);
    logic [NCH-1:0] m = '0;
    for (int i = 0; i < NCH; i++)
      m[i] = (sel == 0) ? pend[i] : (sel == 1) ? miss[i] : (mode[i] != 0);
    return m;
  endfunction
  task automatic model_update();
    bit tk, cmd, fire;
    int op, oldp;
    if (rst) begin
      m_phase = 0;
      m_tick  = 0;
      for (int i = 0; i < NCH; i++) begin
        mode[i] = 0; rem[i] = 0; per[i] = 0; pend[i] = 0; miss[i] = 0; mc[i] = 0;
      end
      return;
    end
    tk = m_tick && bus.enable;
    op = int'(bus.cfg_op);
    for (int i = 0; i < NCH; i++) begin
      cmd  = bus.cfg_we && int'(bus.cfg_ch) == i;
      fire = 0;
      oldp = per[i];
      if (cmd && (op == 1 || op == 2) && oldp != 0) begin
        mode[i] = op;
        rem[i]  = oldp;
      end else if (cmd && op == 3) begin
        mode[i] = 0;
      end else if (tk && mode[i] != 0) begin
        rem[i] = (rem[i] > 1) ? rem[i] - 1 : 0;
        if (rem[i] == 0) begin
          fire = 1;
          if (mode[i] == 1) rem[i] = oldp;
          else mode[i] = 0;
        end
      end
      if (cmd && op == 0) per[i] = int'(bus.cfg_period);
      if (bus.evt_ack[i]) begin
        pend[i] = fire; miss[i] = 0; mc[i] = 0;
      end else if (fire) begin
        if (pend[i]) begin
          miss[i] = 1;
          mc[i]   = (mc[i] < 255) ? mc[i] + 1 : 255;
        end
        pend[i] = 1;
      end
    end
    if (!bus.enable) begin
      m_phase = 0;
      m_tick  = 0;
    end else begin
      m_tick  = (m_phase == PRESC - 1);
      m_phase = (m_phase + 1) % PRESC;
    end
  endtask
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    chk("base_tick", 32'(bus.base_tick), 32'(m_tick));
    chk("evt_pend", 32'(bus.evt_pend), 32'(m_mask(0)));
    chk("miss", 32'(bus.miss), 32'(m_mask(1)));
    chk("busy", 32'(bus.busy), 32'(m_mask(2)));
`ifdef TICK_SCHED_MISS_CNT_EN
    for (int i = 0; i < NCH; i++)
      chk($sformatf("miss_cnt%0d", i), 32'(bus.miss_cnt[8*i +: 8]), 32'(mc[i]));
`endif
    bus.cfg_we  = 1'b0;
    bus.evt_ack = auto_ack & m_mask(0);
  endtask
  task automatic cmd(input int ch, input int op, input int p);
    bus.cfg_we     = 1'b1;
    bus.cfg_ch     = 2'(ch);
    bus.cfg_op     = 2'(op);
    bus.cfg_period = 16'(p);
    step();
  endtask
  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask
  initial begin
    bit found;
    bus.enable = 1'b0; bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_op = '0;
    bus.cfg_period = '0; bus.evt_ack = '0;
    run(2);
    chk("rst_tick", 32'(bus.base_tick), 0);
    chk("rst_pend", 32'(bus.evt_pend), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    rst = 1'b0;
    bus.enable = 1'b1;
    run(20);
    auto_ack = 4'b0011;
    cmd(0, 0, 3);
    cmd(0, 1, 0);
    run(40);
    chk("ch0_nomiss", 32'(bus.miss[0]), 0);
    cmd(1, 0, 2);
    cmd(1, 2, 0);
    chk("ch1_busy", 32'(bus.busy[1]), 1);
    run(24);
    chk("ch1_done", 32'(bus.busy[1]), 0);
    cmd(2, 0, 1);
    cmd(2, 1, 0);
    run(16);
    chk("ch2_miss", 32'(bus.miss[2]), 1);
    cmd(2, 3, 0);
    bus.evt_ack = bus.evt_ack | 4'b0100;
    step();
    chk("ch2_pend_clr", 32'(bus.evt_pend[2]), 0);
    chk("ch2_miss_clr", 32'(bus.miss[2]), 0);
    cmd(3, 0, 2);
    cmd(3, 1, 0);
    found = 0;
    for (int k = 0; k < 60 && !found; k++) begin
      if (m_tick && mode[3] != 0 && rem[3] == 1) found = 1;
      else step();
    end
    if (!found) begin
      total++; bad++;
      $error("FAIL ch3_window observed=none expected=tick_at_count1");
    end
    cmd(3, 3, 0);
    chk("ch3_stop_busy", 32'(bus.busy[3]), 0);
    chk("ch3_stop_pend", 32'(bus.evt_pend[3]), 0);
    cmd(3, 0, 0);
    cmd(3, 1, 0);
    run(3);
    chk("ch3_zero_start", 32'(bus.busy[3]), 0);
    run(5);
    bus.enable = 1'b0;
    run(10);
    chk("dis_tick", 32'(bus.base_tick), 0);
    bus.enable = 1'b1;
    run(30);
    auto_ack = '0;
    for (int k = 0; k < 400; k++) begin
      bus.enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 2) == 0) begin
        bus.cfg_we     = 1'b1;
        bus.cfg_ch     = 2'($urandom_range(0, 3));
        bus.cfg_op     = 2'($urandom_range(0, 3));
        bus.cfg_period = 16'($urandom_range(0, 4));
      end
      bus.evt_ack = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      rst = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;
    bus.enable = 1'b1;
    run(10);
    rst = 1'b1;
    step();
    chk("rst2_pend", 32'(bus.evt_pend), 0);
    chk("rst2_miss", 32'(bus.miss), 0);
    chk("rst2_busy", 32'(bus.busy), 0);
    rst = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
